// File: rtl/tt_um_adder_unit.sv
// tt_um_adder_unit: 4-bit registered add/subtract ALU slice (Tiny Tapeout wrapper)
// Ports: clk, rst_n (async active-low), ena (0 holds state),
//   ui_in  [3:0] A, [7:4] B
//   uio_in [0] cin, [1] sub, [2] acc (used only with ADDER_ACCUM_EN), [7:3] unused
//   uo_out [3:0] S, [4] C, [5] V, [6] Z, [7] N, all registered
//   uio_out / uio_oe tied to 0 (uio pins are inputs only)
// Optional feature: define ADDER_ACCUM_EN so that acc=1 takes A from the registered S.
module tt_um_adder_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] uo_q, uo_d;
  logic [3:0] a, be, s;
  logic       ce, c, v;
  logic       unused;
  assign unused = ^uio_in[7:2];
`ifdef ADDER_ACCUM_EN
  assign a = uio_in[2] ? uo_q[3:0] : ui_in[3:0];
`else
  assign a = ui_in[3:0];
`endif
  always_comb begin
    be = uio_in[1] ? ~ui_in[7:4] : ui_in[7:4];
    ce = uio_in[1] ^ uio_in[0];
    {c, s} = {1'b0, a} + {1'b0, be} + {4'b0, ce};
    v = (a[3] == be[3]) && (s[3] != a[3]);
    uo_d = {s[3], s == 4'h0, v, c, s};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uo_q <= 8'h00;
    else if (ena) uo_q <= uo_d;
  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_adder_unit.sv
// tb_tt_um_adder_unit: randomized self-checking bench for tt_um_adder_unit
module tb_tt_um_adder_unit;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       ena = 0;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q = 0;

  tt_um_adder_unit dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin, input logic sub);
    int r, sr, sa, sb;
    logic [3:0] s;
    logic c, v;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    if (!sub) begin
      r = int'(a) + int'(b) + int'(cin);
      c = r > 15;
      sr = sa + sb + int'(cin);
    end else begin
      r = int'(a) - int'(b) - int'(cin);
      c = r >= 0;
      sr = sa - sb - int'(cin);
    end
    s = 4'(r & 15);
    v = (sr < -8) || (sr > 7);
    return {s[3], s == 4'h0, v, c, s};
  endfunction

  function automatic logic [7:0] model_next();
    logic [3:0] a;
    a = ui_in[3:0];
`ifdef ADDER_ACCUM_EN
    if (uio_in[2]) a = exp_q[3:0];
`endif
    return ref_f(a, ui_in[7:4], uio_in[0], uio_in[1]);
  endfunction

  task automatic step();
    logic [7:0] nx;
    nx = model_next();
    @(posedge clk);
    if (rst_n && ena) exp_q = nx;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    ui_in = 8'($urandom); uio_in = 8'($urandom); ena = 1;
    rst_n = 0; #1;
    n_chk++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo got %h want 00", uo_out); end
    n_chk++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      n_fail++; $display("FAIL reset_uio got out=%h oe=%h want 00/00", uio_out, uio_oe);
    end
    step(); step();
    exp_q = 0;
    n_chk++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_held got %h want 00", uo_out); end
    rst_n = 1;
  endtask

  task automatic test_vectors();
    logic [7:0] ui_t[5]  = '{8'h35, 8'h07, 8'h1F, 8'h53, 8'h35};
    logic [7:0] uio_t[5] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h02};
    logic [7:0] want[5]  = '{8'hA8, 8'hA8, 8'h50, 8'h8E, 8'h12};
    ena = 1;
    for (int i = 0; i < 5; i++) begin
      ui_in = ui_t[i]; uio_in = uio_t[i];
      step();
      n_chk++;
      if (uo_out !== want[i]) begin
        n_fail++; $display("FAIL vector%0d got %h want %h", i, uo_out, want[i]);
      end
      n_chk++;
      if (exp_q !== want[i]) begin
        n_fail++; $display("FAIL model_vector%0d got %h want %h", i, exp_q, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    ena = 1; ui_in = 8'h35; uio_in = 8'h00;
    step();
    ena = 0; ui_in = 8'h1F;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (uo_out !== 8'hA8) begin n_fail++; $display("FAIL hold%0d got %h want a8", i, uo_out); end
    end
    rst_n = 0; #1;
    exp_q = 0;
    n_chk++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL hold_reset got %h want 00", uo_out); end
    step();
    rst_n = 1;
  endtask

  task automatic test_midop_reset();
    ena = 1; ui_in = 8'h53; uio_in = 8'h02;
    step();
    ui_in = 8'h1F; uio_in = 8'h00;
    rst_n = 0; #1;
    exp_q = 0;
    n_chk++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midop_reset got %h want 00", uo_out); end
    rst_n = 1;
    step();
    n_chk++;
    if (uo_out !== 8'h50) begin n_fail++; $display("FAIL first_after_reset got %h want 50", uo_out); end
  endtask

  task automatic test_accum();
    logic [7:0] want[3];
`ifdef ADDER_ACCUM_EN
    want = '{8'h02, 8'h04, 8'h06};
`else
    want = '{8'h02, 8'h02, 8'h02};
`endif
    rst_n = 0; #1; exp_q = 0;
    step();
    rst_n = 1; ena = 1; ui_in = 8'h20; uio_in = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (uo_out !== want[i]) begin n_fail++; $display("FAIL accum%0d got %h want %h", i, uo_out, want[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ui_in = 8'($urandom); uio_in = 8'($urandom);
      ena = ($urandom_range(0, 7) != 0);
      step();
      n_chk++;
      if (uo_out !== exp_q) begin
        n_fail++; $display("FAIL random%0d ui=%h uio=%h got %h want %h", i, ui_in, uio_in, uo_out, exp_q);
      end
      n_chk++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        n_fail++; $display("FAIL random_uio%0d got out=%h oe=%h want 00/00", i, uio_out, uio_oe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_midop_reset();
    test_accum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
